jtag_shifter: RTL

Hardware JTAG initiator: accepts byte-wide shift commands (up to 8 TCK cycles, with per-bit TMS and TDI) from a system-side master and drives TCK/TMS/TDI to an external TAP. It samples TDO on each bit and returns the captured bits as one response byte. It tracks the target's IEEE 1149.1 TAP state from the TMS bits it issues. It sits between an on-chip sequencer (CPU or host bridge) and JTAG pins. This lets the USER-register command protocol (cmd byte, 32-bit address, count, data) be exercised from inside an FPGA instead of from a PC cable.

---
 rtl/jtag_shifter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/jtag_shifter.sv
// jtag_shifter: byte-wide JTAG initiator driving TCK/TMS/TDI, capturing TDO and tracking the TAP state.
module jtag_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       sysclk,
  input  logic       sys_rstn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_nbits,
  input  logic [7:0] cmd_tms,
  input  logic [7:0] cmd_tdi,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_tdo,
  output logic [3:0] tap_state,
  output logic       tck,
  output logic       tms,
  output logic       tdi,
  input  logic       tdo
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, tms_buf_q, tms_buf_d, tdi_buf_q, tdi_buf_d;
  logic [7:0] cap_q, cap_d, rsp_tdo_q, rsp_tdo_d, cap_nxt;
  logic [2:0] idx_q, idx_d, nbits_q, nbits_d;
  logic [3:0] tap_q, tap_d;
  logic       tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic       tdo_m_q, tdo_s_q, last;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    case (s)
      4'd0:    return m ? 4'd0  : 4'd1;
      4'd1:    return m ? 4'd2  : 4'd1;
      4'd2:    return m ? 4'd9  : 4'd3;
      4'd3:    return m ? 4'd5  : 4'd4;
      4'd4:    return m ? 4'd5  : 4'd4;
      4'd5:    return m ? 4'd8  : 4'd6;
      4'd6:    return m ? 4'd7  : 4'd6;
      4'd7:    return m ? 4'd8  : 4'd4;
      4'd8:    return m ? 4'd2  : 4'd1;
      4'd9:    return m ? 4'd0  : 4'd10;
      4'd10:   return m ? 4'd12 : 4'd11;
      4'd11:   return m ? 4'd12 : 4'd11;
      4'd12:   return m ? 4'd15 : 4'd13;
      4'd13:   return m ? 4'd14 : 4'd13;
      4'd14:   return m ? 4'd15 : 4'd11;
      default: return m ? 4'd2  : 4'd1;
    endcase
  endfunction

  assign last      = cnt_q == 8'(CLK_DIV - 1);
  assign cap_nxt   = cap_q | (8'(tdo_s_q) << idx_q);
  assign cmd_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_tdo   = rsp_tdo_q;
  assign tap_state = tap_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    nbits_d   = nbits_q;
    tms_buf_d = tms_buf_q;
    tdi_buf_d = tdi_buf_q;
    cap_d     = cap_q;
    rsp_tdo_d = rsp_tdo_q;
    tap_d     = tap_q;
    tck_d     = tck_q;
    tms_d     = tms_q;
    tdi_d     = tdi_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d   = LOW;
        cnt_d     = '0;
        idx_d     = '0;
        nbits_d   = cmd_nbits;
        tms_buf_d = cmd_tms;
        tdi_buf_d = cmd_tdi;
        cap_d     = '0;
        tck_d     = 1'b0;
        tms_d     = cmd_tms[0];
        tdi_d     = cmd_tdi[0];
      end
      LOW: begin
        cnt_d = last ? '0 : cnt_q + 8'd1;
        if (last) begin
          state_d = HIGH;
          tck_d   = 1'b1;
          tap_d   = tap_next(tap_q, tms_q);
        end
      end
      HIGH: begin
        cnt_d = last ? '0 : cnt_q + 8'd1;
        if (last) begin
          cap_d = cap_nxt;
          if (idx_q != nbits_q) begin
            state_d = LOW;
            idx_d   = idx_q + 3'd1;
            tck_d   = 1'b0;
            tms_d   = tms_buf_q[idx_q + 3'd1];
            tdi_d   = tdi_buf_q[idx_q + 3'd1];
          end else begin
            state_d   = RESP;
            rsp_tdo_d = cap_nxt;
          end
        end
      end
      RESP: if (rsp_ready) state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      nbits_q   <= '0;
      tms_buf_q <= '0;
      tdi_buf_q <= '0;
      cap_q     <= '0;
      rsp_tdo_q <= '0;
      tap_q     <= '0;
      tck_q     <= 1'b0;
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
      tdo_m_q   <= 1'b0;
      tdo_s_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      nbits_q   <= nbits_d;
      tms_buf_q <= tms_buf_d;
      tdi_buf_q <= tdi_buf_d;
      cap_q     <= cap_d;
      rsp_tdo_q <= rsp_tdo_d;
      tap_q     <= tap_d;
      tck_q     <= tck_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
      tdo_m_q   <= tdo;
      tdo_s_q   <= tdo_m_q;
    end
  end
endmodule
